// File: rtl/package_dpd.sv
// Shared types, defaults and FSM encoding for the DPD loop-delay estimator.
package package_dpd;

    typedef logic signed [15:0] s16;
    typedef logic signed [19:0] s20;
    typedef logic signed [47:0] s48;
    typedef logic        [6:0]  u7;

    localparam int unsigned N_CORR_DEF  = 128;
    localparam int unsigned MAX_LAG_DEF = 64;

    typedef enum logic [1:0] {IDLE, CAPTURE, CORR, DONE} state_t;

    function automatic logic [47:0] mag48(input s48 x);
        return x[47] ? 48'(-x) : 48'(x);
    endfunction

endpackage

// File: rtl/dpd_cap_ram.sv
// Simple dual-port capture buffer with a registered read port.
module dpd_cap_ram #(
    parameter int unsigned DEPTH = 192,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [39:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [39:0]   rd_data
);

    logic [39:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dpd_delay_est.sv
// Estimates amplifier loop delay as the lag maximising |Re(ref * conj(fb))|.
module dpd_delay_est import package_dpd::*; #(
    parameter int unsigned N_CORR   = N_CORR_DEF,
    parameter int unsigned MAX_LAG  = MAX_LAG_DEF,
    parameter logic [47:0] MIN_PEAK = 48'd1 << 30
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  s20   ref_i,
    input  s20   ref_q,
    input  s20   fb_i,
    input  s20   fb_q,
    output logic busy,
    output logic done,
    output u7    delay,
    output s48   peak,
    output logic lock
);

    localparam int unsigned N_CAP = N_CORR + MAX_LAG;
    localparam int unsigned AW    = $clog2(N_CAP);
    typedef logic [AW-1:0] addr_t;

    state_t      state, state_nxt;
    addr_t       cap_cnt, n_cnt, lag_cnt;
    logic        iss_done, cap_we, issue;
    logic [39:0] ref_rd, fb_rd;
    logic        rd_v, rd_first, rd_last, rd_fin;
    logic        rg_v, rg_first, rg_last, rg_fin;
    logic        pr_v, pr_first, pr_last, pr_fin;
    s16          ri, rq, fi, fq;
    s48          prod, acc, best, best_nxt;
    u7           best_lag, cmp_lag;
    logic        lag_end, fin, take;
    logic        unused_lsbs;

    assign unused_lsbs = ^{ref_rd[23:20], ref_rd[3:0], fb_rd[23:20], fb_rd[3:0]};

    dpd_cap_ram #(.DEPTH(N_CAP), .AW(AW)) u_ref_ram (
        .clk(clk), .wr_en(cap_we), .wr_addr(cap_cnt), .wr_data({ref_i, ref_q}),
        .rd_addr(n_cnt), .rd_data(ref_rd)
    );

    dpd_cap_ram #(.DEPTH(N_CAP), .AW(AW)) u_fb_ram (
        .clk(clk), .wr_en(cap_we), .wr_addr(cap_cnt), .wr_data({fb_i, fb_q}),
        .rd_addr(addr_t'(n_cnt + lag_cnt)), .rd_data(fb_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: if (cap_cnt == addr_t'(N_CAP - 1)) state_nxt = CORR;
            CORR:    if (fin) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy   = (state == CAPTURE) || (state == CORR);
        done   = (state == DONE);
        cap_we = (state == CAPTURE);
        issue  = (state == CORR) && !iss_done;
    end

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            cap_cnt  <= '0;
            n_cnt    <= '0;
            lag_cnt  <= '0;
            iss_done <= 1'b0;
        end else begin
            if (cap_we) cap_cnt <= cap_cnt + 1'b1;
            if (issue) begin
                if (n_cnt == addr_t'(N_CORR - 1)) begin
                    n_cnt <= '0;
                    if (lag_cnt == addr_t'(MAX_LAG - 1)) iss_done <= 1'b1;
                    else                                 lag_cnt  <= lag_cnt + 1'b1;
                end else begin
                    n_cnt <= n_cnt + 1'b1;
                end
            end
        end
    end

    // Lag-boundary flags ride alongside the data so the accumulator reloads on each lag's first term.
    always_ff @(posedge clk) begin
        if (reset) begin
            {rd_v, rd_first, rd_last, rd_fin} <= '0;
            {rg_v, rg_first, rg_last, rg_fin} <= '0;
            {pr_v, pr_first, pr_last, pr_fin} <= '0;
            {ri, rq, fi, fq} <= '0;
            prod    <= '0;
            acc     <= '0;
            lag_end <= 1'b0;
            fin     <= 1'b0;
        end else begin
            rd_v     <= issue;
            rd_first <= issue && (n_cnt == '0);
            rd_last  <= issue && (n_cnt == addr_t'(N_CORR - 1));
            rd_fin   <= issue && (n_cnt == addr_t'(N_CORR - 1)) && (lag_cnt == addr_t'(MAX_LAG - 1));
            {rg_v, rg_first, rg_last, rg_fin} <= {rd_v, rd_first, rd_last, rd_fin};
            {pr_v, pr_first, pr_last, pr_fin} <= {rg_v, rg_first, rg_last, rg_fin};
            ri   <= ref_rd[39:24];
            rq   <= ref_rd[19:4];
            fi   <= fb_rd[39:24];
            fq   <= fb_rd[19:4];
            prod <= s48'(ri) * s48'(fi) + s48'(rq) * s48'(fq);
            if (pr_v) acc <= pr_first ? prod : acc + prod;
            lag_end <= pr_v && pr_last;
            fin     <= pr_v && pr_fin;
        end
    end

    always_comb begin
        take     = mag48(acc) > mag48(best);
        best_nxt = take ? acc : best;
    end

    // The final lag is judged in the same cycle the result registers load.
    always_ff @(posedge clk) begin
        if (reset) begin
            best     <= '0;
            best_lag <= '0;
            cmp_lag  <= '0;
            delay    <= '0;
            peak     <= '0;
            lock     <= 1'b0;
        end else begin
            if (state == IDLE) begin
                best     <= '0;
                best_lag <= '0;
                cmp_lag  <= '0;
            end else if (lag_end) begin
                if (take) begin
                    best     <= acc;
                    best_lag <= cmp_lag;
                end
                cmp_lag <= cmp_lag + 1'b1;
            end
            if (fin) begin
                delay <= take ? cmp_lag : best_lag;
                peak  <= best_nxt;
                lock  <= mag48(best_nxt) >= MIN_PEAK;
            end
        end
    end

endmodule
